// File: rtl/video_window_out_if.sv
// Framebuffer stream handshake between the pixel output stage and its word source.
// master = word source, slave = video_window_out.
interface video_window_out_if;
  logic [15:0] stream_data_i;
  logic        stream_err_underflow_i;
  logic        stream_ena_o;

  modport master (
    output stream_data_i,
    output stream_err_underflow_i,
    input  stream_ena_o
  );

  modport slave (
    input  stream_data_i,
    input  stream_err_underflow_i,
    output stream_ena_o
  );
endinterface

// File: rtl/video_window_out.sv
// Framebuffer window placement, 1x/2x/4x replication and RGB444/565 expansion ahead of hdmi_encoder.
// Optional: define VIDEO_WINDOW_OUT_UNDERFLOW_EN to paint underflowed pixels red and count them.
module video_window_out #(
  parameter int          FB_WIDTH   = 640,
  parameter int          FB_HEIGHT  = 480,
  parameter int          SCALE      = 1,
  parameter int          X_OFFSET   = 0,
  parameter int          Y_OFFSET   = 0,
  parameter logic [23:0] BORDER_RGB = 24'h202020,
  parameter int          CORDW      = 16
) (
  input  logic               clk_pix,
  input  logic               reset_n_i,
  input  logic               de_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  input  logic               frame_i,
  input  logic               line_i,
  input  logic               fmt565_i,
  video_window_out_if.slave  stream_if,
  output logic [7:0]         vga_r_o,
  output logic [7:0]         vga_g_o,
  output logic [7:0]         vga_b_o,
  output logic               vga_hsync_o,
  output logic               vga_vsync_o,
  output logic               vga_de_o,
  output logic [15:0]        underflow_cnt_o
);
  // state        | meaning
  // S_WAIT_FRAME | syncs/de pass through, pixels black, no pops
  // S_ACTIVE     | window placement and stream consumption running
  localparam logic [0:0] S_WAIT_FRAME = 1'b0;
  localparam logic [0:0] S_ACTIVE     = 1'b1;

  localparam int unsigned AW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam int unsigned SW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
  localparam logic [32:0] X_LO  = 33'(X_OFFSET);
  localparam logic [32:0] Y_LO  = 33'(Y_OFFSET);
  localparam logic [31:0] WIN_W = 32'(FB_WIDTH * SCALE);
  localparam logic [31:0] WIN_H = 32'(FB_HEIGHT * SCALE);

  logic [0:0]       r_state;
  logic             r_fmt565;
  logic [CORDW-1:0] r_col;
  logic [CORDW-1:0] r_row;
  logic [SW-1:0]    r_hsub;
  logic [SW-1:0]    r_vsub;
  logic [AW-1:0]    r_src_x;

  logic [32:0] w_col_rel;
  logic [32:0] w_row_rel;
  logic        w_col_in;
  logic        w_row_in;
  logic        w_inwin;
  logic        w_active;
  logic        w_fetch_row;
  logic        w_pix;
  logic        w_pop;

  // borrow bit of the offset subtraction doubles as the "left of / above window" test
  assign w_col_rel   = {1'b0, 32'(r_col)} - X_LO;
  assign w_row_rel   = {1'b0, 32'(r_row)} - Y_LO;
  assign w_col_in    = !w_col_rel[32] && (w_col_rel[31:0] < WIN_W);
  assign w_row_in    = !w_row_rel[32] && (w_row_rel[31:0] < WIN_H);
  assign w_inwin     = w_col_in && w_row_in;
  assign w_active    = (r_state == S_ACTIVE);
  assign w_fetch_row = (SCALE == 1) || (r_vsub == '0);
  assign w_pix       = w_active && de_i && w_inwin;
  assign w_pop       = w_pix && (r_hsub == '0) && w_fetch_row;

  assign stream_if.stream_ena_o = w_pop;

  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= S_WAIT_FRAME;
      r_fmt565 <= 1'b0;
    end else if (frame_i) begin
      r_state  <= S_ACTIVE;
      r_fmt565 <= fmt565_i;
    end
  end

  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_col   <= '0;
      r_row   <= '0;
      r_hsub  <= '0;
      r_vsub  <= '0;
      r_src_x <= '0;
    end else if (frame_i) begin
      r_col   <= '0;
      r_row   <= '0;
      r_hsub  <= '0;
      r_vsub  <= '0;
      r_src_x <= '0;
    end else if (line_i) begin
      r_col   <= '0;
      r_hsub  <= '0;
      r_src_x <= '0;
      if (r_row != '1) r_row <= r_row + CORDW'(1);
      // vsub advances only when leaving a window line
      if (w_row_in) r_vsub <= (r_vsub == SUB_LAST) ? '0 : r_vsub + SW'(1);
    end else begin
      if (de_i && (r_col != '1)) r_col <= r_col + CORDW'(1);
      if (w_pix) begin
        if (r_hsub == SUB_LAST) begin
          r_hsub  <= '0;
          r_src_x <= r_src_x + AW'(1);
        end else begin
          r_hsub  <= r_hsub + SW'(1);
        end
      end
    end
  end

  logic [15:0] w_lb_q;

  if (SCALE > 1) begin : g_lb
    logic [15:0] r_mem [0:FB_WIDTH-1];
    logic [15:0] r_lb_q;

    always_ff @(posedge clk_pix) begin
      if (w_pop) r_mem[r_src_x] <= stream_if.stream_data_i;
    end

    always_ff @(posedge clk_pix or negedge reset_n_i) begin
      if (!reset_n_i) r_lb_q <= '0;
      else            r_lb_q <= r_mem[r_src_x];
    end

    assign w_lb_q = r_lb_q;
  end else begin : g_no_lb
    assign w_lb_q = '0;
  end

  logic [15:0] r_s1_word;
  logic        r_s1_de;
  logic        r_s1_hs;
  logic        r_s1_vs;
  logic        r_s1_inwin;
  logic        r_s1_fetch;
  logic        r_s1_active;
  logic        r_s1_uf;

  // the word is held across hsub!=0 so fetch rows replicate horizontally
  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_s1_word   <= '0;
      r_s1_de     <= 1'b0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_s1_inwin  <= 1'b0;
      r_s1_fetch  <= 1'b0;
      r_s1_active <= 1'b0;
      r_s1_uf     <= 1'b0;
    end else begin
      if (w_pop) r_s1_word <= stream_if.stream_data_i;
      r_s1_de     <= de_i;
      r_s1_hs     <= hsync_i;
      r_s1_vs     <= vsync_i;
      r_s1_inwin  <= w_inwin;
      r_s1_fetch  <= w_fetch_row;
      r_s1_active <= w_active;
      r_s1_uf     <= stream_if.stream_err_underflow_i;
    end
  end

  logic [15:0] w_word;
  logic [7:0]  w_r8;
  logic [7:0]  w_g8;
  logic [7:0]  w_b8;
  logic [23:0] w_rgb;

  assign w_word = r_s1_fetch ? r_s1_word : w_lb_q;
  assign w_r8   = r_fmt565 ? {w_word[15:11], w_word[15:13]} : {w_word[11:8], w_word[11:8]};
  assign w_g8   = r_fmt565 ? {w_word[10:5],  w_word[10:9]}  : {w_word[7:4],  w_word[7:4]};
  assign w_b8   = r_fmt565 ? {w_word[4:0],   w_word[4:2]}   : {w_word[3:0],  w_word[3:0]};

  always_comb begin
    w_rgb = 24'h000000;
    if (r_s1_active && r_s1_de) begin
      if (!r_s1_inwin) w_rgb = BORDER_RGB;
`ifdef VIDEO_WINDOW_OUT_UNDERFLOW_EN
      else if (r_s1_fetch && r_s1_uf) w_rgb = 24'hFF0000;
`endif
      else w_rgb = {w_r8, w_g8, w_b8};
    end
  end

  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vga_r_o     <= '0;
      vga_g_o     <= '0;
      vga_b_o     <= '0;
      vga_hsync_o <= 1'b0;
      vga_vsync_o <= 1'b0;
      vga_de_o    <= 1'b0;
    end else begin
      vga_r_o     <= w_rgb[23:16];
      vga_g_o     <= w_rgb[15:8];
      vga_b_o     <= w_rgb[7:0];
      vga_hsync_o <= r_s1_hs;
      vga_vsync_o <= r_s1_vs;
      vga_de_o    <= r_s1_de;
    end
  end

`ifdef VIDEO_WINDOW_OUT_UNDERFLOW_EN
  logic [15:0] r_uf_cnt;

  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_uf_cnt <= '0;
    end else if (r_s1_active && r_s1_de && r_s1_inwin && r_s1_fetch && r_s1_uf
                 && (r_uf_cnt != 16'hFFFF)) begin
      r_uf_cnt <= r_uf_cnt + 16'd1;
    end
  end

  assign underflow_cnt_o = r_uf_cnt;

  logic w_unused;
  assign w_unused = ^{1'b0, r_src_x};
`else
  assign underflow_cnt_o = 16'h0000;

  logic w_unused;
  assign w_unused = ^{1'b0, r_src_x, r_s1_uf};
`endif

endmodule

// File: tb/tb_video_window_out.sv
// Directed bench: three window configurations driven from one small raster (16x8, 12x6 active).
module tb_video_window_out;
  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  logic reset_n_i, de_i, hsync_i, vsync_i, frame_i, line_i, fmt565_i, tb_uf;

  int cur_f, cur_vy, cur_hx;
  int idx_s1, idx_s2, idx_o;
  int pops_s1 [0:3][0:7];
  int pops_s2 [0:3][0:7];
  int pops_o  [0:3][0:7];
  int first_vy = -1;
  int first_hx = -1;
  int n_chk = 0;
  int n_fail = 0;

  logic [23:0] cap_s1 [0:3][0:7][0:15];
  logic [23:0] cap_s2 [0:3][0:7][0:15];
  logic [23:0] cap_o  [0:3][0:7][0:15];
  logic        cap_de_s1 [0:3][0:7][0:15];
  logic        cap_hs_s1 [0:3][0:7][0:15];
  logic        cap_vs_s1 [0:3][0:7][0:15];
  int p_f, p_vy, p_hx;
  bit p_valid;

  logic [7:0]  s1_r, s1_g, s1_b, s2_r, s2_g, s2_b, o_r, o_g, o_b;
  logic        s1_hs, s1_vs, s1_de, s2_hs, s2_vs, s2_de, o_hs, o_vs, o_de;
  logic [15:0] s1_cnt, s2_cnt, o_cnt;

  video_window_out_if s1_if ();
  video_window_out_if s2_if ();
  video_window_out_if o_if ();

  function automatic logic [15:0] word_s1(input int k, input int f);
    if (f == 0) return 16'h0ABC + 16'(k);
    return 16'hF81F;
  endfunction

  function automatic logic [15:0] word_s2(input int k);
    return 16'(16'h0111 * (k + 1));
  endfunction

  function automatic logic [15:0] word_o(input int k);
    return 16'h0100 + 16'(k);
  endfunction

  assign s1_if.stream_data_i          = word_s1(idx_s1, cur_f);
  assign s1_if.stream_err_underflow_i = 1'b0;
  assign s2_if.stream_data_i          = word_s2(idx_s2);
  assign s2_if.stream_err_underflow_i = 1'b0;
  assign o_if.stream_data_i           = word_o(idx_o);
  assign o_if.stream_err_underflow_i  = tb_uf;

  video_window_out #(.FB_WIDTH(8), .FB_HEIGHT(4), .SCALE(1), .X_OFFSET(0), .Y_OFFSET(0)) u_s1 (
    .clk_pix(clk_pix), .reset_n_i(reset_n_i), .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .frame_i(frame_i), .line_i(line_i), .fmt565_i(fmt565_i), .stream_if(s1_if),
    .vga_r_o(s1_r), .vga_g_o(s1_g), .vga_b_o(s1_b), .vga_hsync_o(s1_hs), .vga_vsync_o(s1_vs),
    .vga_de_o(s1_de), .underflow_cnt_o(s1_cnt));

  video_window_out #(.FB_WIDTH(4), .FB_HEIGHT(2), .SCALE(2), .X_OFFSET(0), .Y_OFFSET(0)) u_s2 (
    .clk_pix(clk_pix), .reset_n_i(reset_n_i), .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .frame_i(frame_i), .line_i(line_i), .fmt565_i(fmt565_i), .stream_if(s2_if),
    .vga_r_o(s2_r), .vga_g_o(s2_g), .vga_b_o(s2_b), .vga_hsync_o(s2_hs), .vga_vsync_o(s2_vs),
    .vga_de_o(s2_de), .underflow_cnt_o(s2_cnt));

  video_window_out #(.FB_WIDTH(8), .FB_HEIGHT(4), .SCALE(1), .X_OFFSET(3), .Y_OFFSET(1)) u_o (
    .clk_pix(clk_pix), .reset_n_i(reset_n_i), .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .frame_i(frame_i), .line_i(line_i), .fmt565_i(fmt565_i), .stream_if(o_if),
    .vga_r_o(o_r), .vga_g_o(o_g), .vga_b_o(o_b), .vga_hsync_o(o_hs), .vga_vsync_o(o_vs),
    .vga_de_o(o_de), .underflow_cnt_o(o_cnt));

  // word source: show-ahead, advances on pop, restarts at frame start
  always @(posedge clk_pix) begin
    if (frame_i) begin
      idx_s1 <= 0;
      idx_s2 <= 0;
      idx_o  <= 0;
    end else begin
      if (s1_if.stream_ena_o) idx_s1 <= idx_s1 + 1;
      if (s2_if.stream_ena_o) idx_s2 <= idx_s2 + 1;
      if (o_if.stream_ena_o)  idx_o  <= idx_o + 1;
    end
    if (s1_if.stream_ena_o) pops_s1[cur_f][cur_vy] <= pops_s1[cur_f][cur_vy] + 1;
    if (s2_if.stream_ena_o) pops_s2[cur_f][cur_vy] <= pops_s2[cur_f][cur_vy] + 1;
    if (o_if.stream_ena_o)  pops_o[cur_f][cur_vy]  <= pops_o[cur_f][cur_vy] + 1;
    if (o_if.stream_ena_o && cur_f == 0 && first_vy < 0) begin
      first_vy <= cur_vy;
      first_hx <= cur_hx;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // outputs seen after a step belong to the previous step's inputs (2-cycle latency)
  task automatic do_line(input int f, input int vy, input bit frame_start, input bit de_on, input int n_hx);
    for (int hx = 0; hx < n_hx; hx++) begin
      frame_i = frame_start && (hx == 0);
      line_i  = (hx == 0);
      de_i    = de_on && (hx >= 2) && (hx < 14);
      hsync_i = (hx >= 14);
      vsync_i = (vy == 7);
      tb_uf   = (f == 0) && (vy == 2) && (hx >= 5) && (hx <= 9);
      cur_f = f; cur_vy = vy; cur_hx = hx;
      @(posedge clk_pix);
      #1;
      if (p_valid) begin
        cap_s1[p_f][p_vy][p_hx]    = {s1_r, s1_g, s1_b};
        cap_s2[p_f][p_vy][p_hx]    = {s2_r, s2_g, s2_b};
        cap_o[p_f][p_vy][p_hx]     = {o_r, o_g, o_b};
        cap_de_s1[p_f][p_vy][p_hx] = s1_de;
        cap_hs_s1[p_f][p_vy][p_hx] = s1_hs;
        cap_vs_s1[p_f][p_vy][p_hx] = s1_vs;
      end
      p_f = f; p_vy = vy; p_hx = hx; p_valid = 1'b1;
    end
  endtask

  task automatic do_frame(input int f);
    for (int vy = 0; vy < 8; vy++) begin
      if (f == 1 && vy == 1) fmt565_i = 1'b0;
      do_line(f, vy, vy == 0, vy < 6, 16);
    end
  endtask

  initial begin
    reset_n_i = 1'b0; de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
    frame_i = 1'b0; line_i = 1'b0; fmt565_i = 1'b0; tb_uf = 1'b0;
    p_valid = 1'b0;
    repeat (3) @(posedge clk_pix);
    #1;
    chk("rst_rgb_s1", 32'({s1_r, s1_g, s1_b}), 32'h0);
    chk("rst_de_s1", 32'(s1_de), 32'h0);
    chk("rst_cnt_o", 32'(o_cnt), 32'h0);
    reset_n_i = 1'b1;

    fmt565_i = 1'b0;
    do_frame(0);

    chk("s1_r0c0_444", 32'(cap_s1[0][0][2]), 32'hAABBCC);
    chk("s1_r0c1_444", 32'(cap_s1[0][0][3]), 32'hAABBDD);
    chk("s1_r3c7_444", 32'(cap_s1[0][3][9]), 32'hAADDBB);
    chk("s1_r0c8_border", 32'(cap_s1[0][0][10]), 32'h202020);
    chk("s1_r4_border", 32'(cap_s1[0][4][2]), 32'h202020);
    chk("s1_blank_black", 32'(cap_s1[0][0][0]), 32'h0);
    chk("s1_de_lat_on", 32'(cap_de_s1[0][0][2]), 32'h1);
    chk("s1_de_lat_off", 32'(cap_de_s1[0][0][1]), 32'h0);
    chk("s1_hs_lat_on", 32'(cap_hs_s1[0][0][14]), 32'h1);
    chk("s1_hs_lat_off", 32'(cap_hs_s1[0][0][13]), 32'h0);
    chk("s1_vs_lat_on", 32'(cap_vs_s1[0][7][3]), 32'h1);
    chk("s1_vs_lat_off", 32'(cap_vs_s1[0][6][3]), 32'h0);
    chk("s1_pops_line0", 32'(pops_s1[0][0]), 32'd8);
    chk("s1_pops_frame", 32'(pops_s1[0][0] + pops_s1[0][1] + pops_s1[0][2] + pops_s1[0][3]
                             + pops_s1[0][4] + pops_s1[0][5]), 32'd32);

    chk("s2_r0c0", 32'(cap_s2[0][0][2]), 32'h111111);
    chk("s2_r0c1", 32'(cap_s2[0][0][3]), 32'h111111);
    chk("s2_r0c2", 32'(cap_s2[0][0][4]), 32'h222222);
    chk("s2_r1c0_replay", 32'(cap_s2[0][1][2]), 32'h111111);
    chk("s2_r1c2_replay", 32'(cap_s2[0][1][4]), 32'h222222);
    chk("s2_r1c7_replay", 32'(cap_s2[0][1][9]), 32'h444444);
    chk("s2_r2c0", 32'(cap_s2[0][2][2]), 32'h555555);
    chk("s2_r3c7_replay", 32'(cap_s2[0][3][9]), 32'h888888);
    chk("s2_r0c8_border", 32'(cap_s2[0][0][10]), 32'h202020);
    chk("s2_pops_fetch", 32'(pops_s2[0][0]), 32'd4);
    chk("s2_pops_replay", 32'(pops_s2[0][1]), 32'd0);
    chk("s2_pops_frame", 32'(pops_s2[0][0] + pops_s2[0][1] + pops_s2[0][2] + pops_s2[0][3]
                             + pops_s2[0][4] + pops_s2[0][5]), 32'd8);

    chk("o_row0_border", 32'(cap_o[0][0][2]), 32'h202020);
    chk("o_r1c2_border", 32'(cap_o[0][1][4]), 32'h202020);
    chk("o_r1c3_first", 32'(cap_o[0][1][5]), 32'h110000);
    chk("o_r1c11_border", 32'(cap_o[0][1][13]), 32'h202020);
    chk("o_de0_black", 32'(cap_o[0][1][0]), 32'h0);
    chk("o_first_pop_row", 32'(first_vy), 32'd1);
    chk("o_first_pop_hx", 32'(first_hx), 32'd5);
    chk("o_pops_row0", 32'(pops_o[0][0]), 32'd0);
    chk("o_pops_frame", 32'(pops_o[0][1] + pops_o[0][2] + pops_o[0][3] + pops_o[0][4]
                            + pops_o[0][5]), 32'd32);
`ifdef VIDEO_WINDOW_OUT_UNDERFLOW_EN
    chk("o_uf_first", 32'(cap_o[0][2][5]), 32'hFF0000);
    chk("o_uf_last", 32'(cap_o[0][2][9]), 32'hFF0000);
    chk("o_uf_cnt", 32'(o_cnt), 32'd5);
`else
    chk("o_uf_first", 32'(cap_o[0][2][5]), 32'h110088);
    chk("o_uf_last", 32'(cap_o[0][2][9]), 32'h1100CC);
    chk("o_uf_cnt", 32'(o_cnt), 32'd0);
`endif
    chk("o_after_uf", 32'(cap_o[0][2][10]), 32'h1100DD);

    fmt565_i = 1'b1;
    do_frame(1);
    do_frame(2);

    chk("s1_565_r0c0", 32'(cap_s1[1][0][2]), 32'hFF00FF);
    chk("s1_565_hold", 32'(cap_s1[1][2][2]), 32'hFF00FF);
    chk("s1_444_next", 32'(cap_s1[2][0][2]), 32'h8811FF);
    chk("o_resync", 32'(cap_o[2][1][5]), 32'h110000);
`ifdef VIDEO_WINDOW_OUT_UNDERFLOW_EN
    chk("o_uf_cnt_hold", 32'(o_cnt), 32'd5);
`else
    chk("o_uf_cnt_hold", 32'(o_cnt), 32'd0);
`endif

    do_line(3, 0, 1'b0, 1'b1, 8);
    chk("pre_rst_border", 32'({s1_r, s1_g, s1_b}), 32'h202020);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("async_rst_rgb", 32'({s1_r, s1_g, s1_b}), 32'h0);
    chk("async_rst_de", 32'(s1_de), 32'h0);
    chk("async_rst_cnt", 32'(o_cnt), 32'h0);
    @(posedge clk_pix);
    #1;
    reset_n_i = 1'b1;
    p_valid = 1'b0;
    do_line(3, 1, 1'b0, 1'b1, 16);
    chk("wait_black", 32'(cap_s1[3][1][6]), 32'h0);
    chk("wait_de_pass", 32'(cap_de_s1[3][1][6]), 32'h1);
    chk("wait_no_pop_s1", 32'(pops_s1[3][1]), 32'd0);
    chk("wait_no_pop_s2", 32'(pops_s2[3][1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/video_window_out.md
Name: video_window_out

Overview:
- Parametrised pixel-output stage between display_timings, the framebuffer output stream and hdmi_encoder.
- Places an FB_WIDTH x FB_HEIGHT framebuffer window at a programmable offset inside the display raster.
- Applies integer pixel replication (1x/2x/4x) with a line buffer for vertical repeat, and converts RGB444 or RGB565 to 8-bit channels.
- Generates the stream pop strobe and paints the border outside the window.

Parameters:
- FB_WIDTH, 640, source framebuffer width in words.
- FB_HEIGHT, 480, source framebuffer height in lines.
- SCALE, 1, replication factor; legal values 1, 2, 4.
- X_OFFSET, 0, first display column of the window.
- Y_OFFSET, 0, first display line of the window.
- BORDER_RGB, 24'h202020, output colour outside the window while de=1.
- CORDW, 16, coordinate width; matches display_timings.

Ports:
- clk_pix  in  1  pixel clock.
- reset_n_i  in  1  asynchronous active-low reset.
- de_i  in  1  display data enable.
- hsync_i  in  1  display hsync.
- vsync_i  in  1  display vsync.
- frame_i  in  1  one-cycle pulse at frame start.
- line_i  in  1  one-cycle pulse at line start.
- fmt565_i  in  1  0=RGB444 in [11:0]; 1=RGB565; sampled only on frame_i.
- stream_data_i  in  16  show-ahead stream word, valid while not underflowing.
- stream_err_underflow_i  in  1  stream underflow flag.
- stream_ena_o  out  1  combinational pop; word consumed at the clock edge.
- vga_r_o  out  8  red.
- vga_g_o  out  8  green.
- vga_b_o  out  8  blue.
- vga_hsync_o  out  1  hsync delayed to match pixels.
- vga_vsync_o  out  1  vsync delayed to match pixels.
- vga_de_o  out  1  de delayed to match pixels.
- underflow_cnt_o  out  16  underflow pixel count (optional feature only).

Behaviour:
- Reset is asynchronous and active-low. All outputs, counters and pipeline registers clear to 0. State goes to WAIT_FRAME and the format register to RGB444.
- State WAIT_FRAME:
  - Outputs pass through syncs and de; pixels are forced black.
  - stream_ena_o=0.
  - Moves to ACTIVE on frame_i.
- State ACTIVE: returns to WAIT_FRAME only on reset. frame_i re-arms all counters in the same cycle.
- Counters:
  - col: cleared on line_i/frame_i, increments on de_i.
  - row: cleared on frame_i, increments on line_i.
  - Both are CORDW bits and saturate at their maximum value.
- Window:
  - inwin = col in [X_OFFSET, X_OFFSET+FB_WIDTH*SCALE).
  - and row in [Y_OFFSET, Y_OFFSET+FB_HEIGHT*SCALE).
- Sub-pixel counters:
  - hsub wraps 0..SCALE-1 inside the window.
  - vsub wraps 0..SCALE-1 per window line.
  - A source word is presented when hsub==0.
- Fetch row (vsub==0):
  - stream_ena_o = de_i & inwin & hsub==0.
  - The word is written to the line buffer at address src_x, range 0..FB_WIDTH-1.
  - The pixel takes the stream word.
- Replay row (vsub!=0):
  - stream_ena_o=0.
  - The pixel takes the line buffer word at src_x.
- Line buffer: FB_WIDTH x 16, synchronous read, one write port. It is only instantiated when SCALE>1; for SCALE=1 every window row is a fetch row.
- Pipeline: 2 stages.
  - Stage 1 registers the stream word, the inwin/de/sync flags and the underflow flag, and issues the buffer read.
  - Stage 2 muxes the word, converts it and registers the outputs.
  - Latency is 2 clk_pix for pixels and syncs alike.
- Conversion (bit replication):
  - RGB444: each 4-bit channel c becomes {c,c}.
  - RGB565: R5 becomes {r,r[4:2]}; G6 becomes {g,g[5:4]}; B5 becomes {b,b[4:2]}.
- Output colour:
  - de=1 and outside the window: BORDER_RGB.
  - de=0: black.
- Clipping: when the window extends past the active area, the clipped words are not popped. The stream resynchronises at the next frame start.
- Simultaneous frame_i and line_i: frame_i wins; row=0 and col=0.
- A format change takes effect only on frame_i. A mid-frame toggle is ignored until the next frame.

Optional Feature:
- Macro VIDEO_WINDOW_OUT_UNDERFLOW_EN.
- Defined:
  - Window pixels in fetch rows with stream_err_underflow_i=1 output FF0000.
  - underflow_cnt_o increments once per such pixel, saturates at FFFF and clears on reset only.
- Undefined:
  - The underflow flag is ignored; the pixel shows stream_data_i as is.
  - underflow_cnt_o is tied to 0.

Test Plan:
- SCALE=1, offsets 0, 8x4 window, RGB444, stream word 0x0ABC at col 0 -> vga 0xAA,0xBB,0xCC 2 cycles later; 8 pops per line; 32 pops per frame.
- SCALE=2, 4x2 window, words 0x0111,0x0222,... -> each word appears on 2 adjacent pixels and 2 lines; 4 pops per source line; the replay line makes 0 pops and its output is identical.
- X_OFFSET=3, Y_OFFSET=1, de high -> cols 0-2 and row 0 show 0x202020; first pop at col 3 of row 1; de=0 gives 000000.
- fmt565_i=1 latched at frame_i, word 0xF81F -> FF,00,FF; toggling fmt565_i mid-frame leaves the format unchanged until the next frame_i.
- UNDERFLOW_EN defined, underflow held for 5 window pixels -> 5 pixels FF0000, underflow_cnt_o=5; undefined -> count 0 and stream colour shown.
- reset_n_i low mid-line -> outputs 0 immediately with no clock; after release, pixels stay black and stream_ena_o=0 until the first frame_i.
